// File: rtl/swi_vector_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : swi_vector_unit_pkg
//  Description : Shared state codes, default sizes and fault vector for the
//                software-interrupt vector unit.
//  Revision    : 1.0  initial release
// ============================================================================
package swi_vector_unit_pkg;

    // FSM state codes
    localparam logic [1:0] SVU_ST_IDLE   = 2'd0;
    localparam logic [1:0] SVU_ST_BRANCH = 2'd1;
    localparam logic [1:0] SVU_ST_FLUSH  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = SVU_ST_IDLE,
        ST_BRANCH = SVU_ST_BRANCH,
        ST_FLUSH  = SVU_ST_FLUSH
    } svu_state_e;

    // Default sizing
    localparam int          SVU_BANK_W      = 12;
    localparam int          SVU_NUM_BANKS   = 3;
    localparam int          SVU_STACK_DEPTH = 4;
    localparam int          SVU_FLUSH_CYC   = 2;
    localparam logic [47:0] SVU_FAULT_VEC   = 48'h0000_0000_0010;

endpackage
`default_nettype wire

// File: rtl/swi_link_stack.sv
`default_nettype none
// ============================================================================
//  Module      : swi_link_stack
//  Description : Hardware LIFO of SWI return addresses. Push and pop are
//                never issued together; a push when full or a pop when empty
//                is ignored (the caller turns those into a fault vector).
//  Revision    : 1.0  initial release
// ============================================================================
module swi_link_stack #(
    parameter  int DEPTH  = 4,
    parameter  int DATA_W = 48,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int CNT_W  = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_top,
    output logic [CNT_W-1:0]  o_depth,
    output logic              o_full,
    output logic              o_empty
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [CNT_W-1:0]  depth_q;
    logic [CNT_W-1:0]  depth_d;
    logic [IDX_W-1:0]  w_top_idx;

    assign o_full    = (depth_q == CNT_W'(DEPTH));
    assign o_empty   = (depth_q == '0);
    // Low bits wrap correctly at depth==DEPTH (e.g. 3'b100 -> index 3)
    assign w_top_idx = depth_q[IDX_W-1:0] - IDX_W'(1);
    assign o_top     = o_empty ? '0 : mem_q[w_top_idx];
    assign o_depth   = depth_q;

    // Next-state: write at the current depth on push, shrink on pop
    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (i_push && !o_full) begin
            mem_d[depth_q[IDX_W-1:0]] = i_data;
            depth_d                   = depth_q + CNT_W'(1);
        end else if (i_pop && !o_empty) begin
            depth_d = depth_q - CNT_W'(1);
        end
    end

    // Storage and depth registers
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            mem_q   <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/swi_vector_unit.sv
`default_nettype none
// ============================================================================
//  Module      : swi_vector_unit
//  Description : Software-interrupt sequencer. Holds the LUIui upper banks,
//                composes {banks, imm} SWI vectors, keeps a link stack for
//                SWI/SRET nesting, pulses a branch and then masks requests
//                while the front end flushes.
//  Option      : SWI_BANK_CLR_EN - clear all banks when an SWI is accepted
//                (a same-cycle LUIui write still lands).
//  Revision    : 1.0  initial release
// ============================================================================
module swi_vector_unit
    import swi_vector_unit_pkg::*;
#(
    parameter  int BANK_W      = SVU_BANK_W,
    parameter  int NUM_BANKS   = SVU_NUM_BANKS,
    parameter  int STACK_DEPTH = SVU_STACK_DEPTH,
    parameter  int FLUSH_CYC   = SVU_FLUSH_CYC,
    parameter  logic [(NUM_BANKS+1)*BANK_W-1:0] FAULT_VEC = SVU_FAULT_VEC,
    localparam int ADDR_W      = (NUM_BANKS + 1) * BANK_W,
    localparam int BANK_IDX_W  = $clog2(NUM_BANKS),
    localparam int DEPTH_W     = $clog2(STACK_DEPTH) + 1,
    localparam int CNT_W       = $clog2(FLUSH_CYC + 1)
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    input  logic                  iw_stall,
    input  logic                  iw_lui_valid,
    input  logic [BANK_IDX_W-1:0] iw_lui_bank,
    input  logic [BANK_W-1:0]     iw_lui_val,
    input  logic                  iw_swi_valid,
    input  logic [ADDR_W-1:0]     iw_swi_pc,
    input  logic [BANK_W-1:0]     iw_swi_imm,
    input  logic                  iw_ret_valid,
    output logic                  ow_ready,
    output logic                  ow_branch_taken,
    output logic [ADDR_W-1:0]     ow_branch_pc,
    output logic [ADDR_W-1:0]     ow_lr,
    output logic [DEPTH_W-1:0]    ow_depth,
    output logic                  ow_fault
);

    svu_state_e                          state_q, state_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [ADDR_W-1:0]                   target_q, target_d;
    logic                                fault_q, fault_d;
    logic [NUM_BANKS-1:0][BANK_W-1:0]    bank_q, bank_d;

    logic              w_swi_acc;
    logic              w_ret_acc;
    logic              w_ovf;
    logic              w_unf;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_top;

    // Requests only land in IDLE and never while stalled; SWI beats SRET
    assign w_swi_acc = !iw_stall && (state_q == ST_IDLE) && iw_swi_valid;
    assign w_ret_acc = !iw_stall && (state_q == ST_IDLE) && iw_ret_valid && !iw_swi_valid;
    assign w_ovf     = w_swi_acc && w_full;
    assign w_unf     = w_ret_acc && w_empty;
    assign w_push    = w_swi_acc && !w_full;
    assign w_pop     = w_ret_acc && !w_empty;

    swi_link_stack #(
        .DEPTH  (STACK_DEPTH),
        .DATA_W (ADDR_W)
    ) u_link_stack (
        .clk     (iw_clk),
        .rst     (iw_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (iw_swi_pc + ADDR_W'(1)),
        .o_top   (w_top),
        .o_depth (ow_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign ow_ready        = (state_q == ST_IDLE);
    assign ow_branch_taken = (state_q == ST_BRANCH);
    assign ow_branch_pc    = target_q;
    assign ow_fault        = (state_q == ST_BRANCH) && fault_q;
    assign ow_lr           = w_top;

    // Next-state, target mux, flush counter and bank updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        fault_d  = fault_q;
        bank_d   = bank_q;
        if (!iw_stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (w_swi_acc || w_ret_acc) begin
                        state_d = ST_BRANCH;
                        fault_d = w_ovf || w_unf;
                        if (w_ovf || w_unf) begin
                            target_d = FAULT_VEC;
                        end else if (w_swi_acc) begin
                            // Old bank values: the LUIui below lands after this edge
                            target_d = {bank_q, iw_swi_imm};
                        end else begin
                            target_d = w_top;
                        end
                    end
                end
                ST_BRANCH: begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYC - 1);
                end
                ST_FLUSH: begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
`ifdef SWI_BANK_CLR_EN
            if (w_swi_acc) begin
                bank_d = '0;
            end
`endif
            // LUIui is taken in every state and overrides any clear
            if (iw_lui_valid) begin
                for (int b = 0; b < NUM_BANKS; b++) begin
                    if (iw_lui_bank == BANK_IDX_W'(b)) begin
                        bank_d[b] = iw_lui_val;
                    end
                end
            end
        end
    end

    // State, counter, target and bank registers
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            fault_q  <= 1'b0;
            bank_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            fault_q  <= fault_d;
            bank_q   <= bank_d;
        end
    end

endmodule
`default_nettype wire
